// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Controller states; encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sa_state_e;

  // Bit counter width: one extra bit so WIDTH=1 and powers of two never wrap early.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Gate-level one-bit full adder cell.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic axb;
  logic gen;
  logic prop;

  assign axb  = a_i ^ b_i;
  assign s_o  = axb ^ c_i;
  assign gen  = a_i & b_i;
  assign prop = axb & c_i;
  assign co_o = gen | prop;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {carryout, sum} = a + b + carryin, one bit per clock, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] acc_shift;

  serial_adder_fa u_fa (
    .a_i  (op_a_q[0]),
    .b_i  (op_b_q[0]),
    .c_i  (cy_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Next-state logic: operand load on accepted start, one bit per cycle in StRun.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    co_d    = co_q;

    // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    acc_shift            = acc_q >> 1;
    acc_shift[WIDTH-1]   = fa_s;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          op_a_d  = a;
          op_b_d  = b;
          cy_d    = carryin;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d  = acc_shift;
        op_a_d = op_a_q >> 1;
        op_b_d = op_b_q >> 1;
        cy_d   = fa_co;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          sum_d   = acc_shift;
          co_d    = fa_co;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign carryout = co_q;

endmodule
